// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: shadowed digit codes, frame-boundary
// display update, BCD/hex decode, leading-zero blanking. Optional DP path via SEG7_DP_EN.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 3000,
    parameter int BLANK    = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  hex_mode,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PC_MAX  = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [PW-1:0]              pcnt_q, pcnt_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [DIGITS-1:0][3:0]     shadow_q, shadow_d;
    logic [DIGITS-1:0][3:0]     disp_q, disp_d;
    logic                       pending_q, pending_d;
    logic [6:0]                 seg_q, seg_d;
    logic [DIGITS-1:0]          an_q, an_d;
    logic                       tick;
    logic                       zero_above, lz_hit;

    function automatic logic [6:0] decode(input logic [3:0] code, input logic hex);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (!hex && code > 4'd9) s = 7'b1111111;
        return s;
    endfunction

    assign tick       = (pcnt_q == PC_MAX) && (idx_q == IDX_MAX);
    assign frame_tick = tick;
    assign seg        = seg_q;
    assign an         = an_q;

    always_comb begin
        pcnt_d    = pcnt_q + PW'(1);
        idx_d     = idx_q;
        if (pcnt_q == PC_MAX) begin
            pcnt_d = '0;
            idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        // Boundary transfer uses the old shadow; a coincident load re-arms pending.
        if (tick && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = data;
            pending_d = 1'b1;
        end
    end

    // A digit is a leading zero when it and every more significant digit are 0.
    always_comb begin
        zero_above = 1'b1;
        lz_hit     = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (disp_q[i] == 4'd0);
            if (zero_above && idx_q == IW'(i)) lz_hit = 1'b1;
        end
        seg_d = (lz_blank && lz_hit) ? 7'b1111111 : decode(disp_q[idx_q], hex_mode);
        an_d  = '1;
        if (32'(pcnt_q) >= BLANK) an_d[idx_q] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q    <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            seg_q     <= 7'b1111111;
            an_q      <= '1;
        end else begin
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

`ifdef SEG7_DP_EN
    logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic              dp_q, dp_d;

    always_comb begin
        shadow_dp_d = load ? dp_in : shadow_dp_q;
        disp_dp_d   = (tick && pending_q) ? shadow_dp_q : disp_dp_q;
        dp_d        = ~disp_dp_q[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_dp_q <= '0;
            disp_dp_q   <= '0;
            dp_q        <= 1'b1;
        end else begin
            shadow_dp_q <= shadow_dp_d;
            disp_dp_q   <= disp_dp_d;
            dp_q        <= dp_d;
        end
    end

    assign dp = dp_q;
`else
    logic unused_dp_in;
    assign unused_dp_in = ^dp_in;
    assign dp = 1'b1;
`endif
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at DIGITS=4, PRESCALE=4, BLANK=1 (16-cycle frame).
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        hex_mode;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .BLANK(1)) dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
        .hex_mode(hex_mode), .lz_blank(lz_blank), .seg(seg), .dp(dp),
        .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) break;
        end
        chk("wait_tick", {7'd0, frame_tick}, 8'd1);
    endtask

    // Call on a frame_tick negedge; walks one frame and ends on the next tick.
    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpv);
        logic [6:0] s [4];
        logic       edp;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (k % 4 == 2) chk({tag, "_blank_an"}, {4'd0, an}, 8'hF);
            if (k % 4 == 0) begin
`ifdef SEG7_DP_EN
                edp = ~dpv[k/4-1];
`else
                edp = 1'b1;
`endif
                chk({tag, "_an"}, {4'd0, an}, {4'd0, ~(4'b0001 << (k/4-1))});
                chk({tag, "_seg"}, {1'b0, seg}, {1'b0, s[k/4-1]});
                chk({tag, "_dp"}, {7'd0, dp}, {7'd0, edp});
            end
        end
        chk({tag, "_tick"}, {7'd0, frame_tick}, 8'd1);
    endtask

    // From a tick negedge: load mid-frame, then advance to the next tick.
    task automatic load_mid(input logic [15:0] d, input logic [3:0] p);
        repeat (3) @(negedge clk);
        load = 1'b1; data = d; dp_in = p;
        @(negedge clk);
        load = 1'b0;
        wait_tick();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data = '0; dp_in = '0; hex_mode = 1'b0; lz_blank = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_an", {4'd0, an}, 8'hF);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_dp", {7'd0, dp}, 8'd1);
        chk("rst_tick", {7'd0, frame_tick}, 8'd0);
        rst = 1'b0;

        // First slot: one blank cycle then digit 0 enabled.
        @(negedge clk); chk("post_rst_n1_an", {4'd0, an}, 8'hF);
        @(negedge clk); chk("post_rst_n2_an", {4'd0, an}, 8'hE);
        chk("post_rst_n2_seg", {1'b0, seg}, {1'b0, 7'b0000001});
        repeat (2) @(negedge clk); chk("post_rst_n4_an", {4'd0, an}, 8'hE);
        @(negedge clk); chk("post_rst_n5_an", {4'd0, an}, 8'hF);
        @(negedge clk); chk("post_rst_n6_an", {4'd0, an}, 8'hD);
        repeat (8) @(negedge clk); chk("post_rst_n14_tick", {7'd0, frame_tick}, 8'd0);
        @(negedge clk); chk("post_rst_n15_tick", {7'd0, frame_tick}, 8'd1);

        // Load mid-frame: current frame keeps showing the old display.
        repeat (3) @(negedge clk);
        load = 1'b1; data = 16'h1234;
        @(negedge clk); load = 1'b0;
        chk("pre_xfer_seg", {1'b0, seg}, {1'b0, 7'b0000001});
        wait_tick();
        check_frame("bcd1234", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 4'b0000);

        hex_mode = 1'b1;
        load_mid(16'hABCD, 4'b0000);
        check_frame("hexABCD", 7'b1000010, 7'b0110001, 7'b1100000, 7'b0001000, 4'b0000);
        hex_mode = 1'b0;
        check_frame("nohexABCD", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 4'b0000);

        lz_blank = 1'b1;
        load_mid(16'h0050, 4'b0000);
        check_frame("lz0050", 7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111, 4'b0000);
        load_mid(16'h0000, 4'b0000);
        check_frame("lz0000", 7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111, 4'b0000);
        lz_blank = 1'b0;

        // Latest load wins; a load on the tick cycle waits for the following boundary.
        repeat (3) @(negedge clk);
        load = 1'b1; data = 16'h1111;
        @(negedge clk); data = 16'h2222;
        @(negedge clk); load = 1'b0;
        wait_tick();
        load = 1'b1; data = 16'h3333; dp_in = 4'b0100;
        check_frame("latest2222", 7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010, 4'b0000);
        check_frame("coinc3333", 7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110, 4'b0100);

        // Asynchronous reset mid-slot discards a pending load.
        repeat (3) @(negedge clk);
        load = 1'b1; data = 16'h1234;
        @(negedge clk); load = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_an", {4'd0, an}, 8'hF);
        chk("mid_rst_seg", {1'b0, seg}, 8'h7F);
        chk("mid_rst_dp", {7'd0, dp}, 8'd1);
        chk("mid_rst_tick", {7'd0, frame_tick}, 8'd0);
        @(negedge clk); rst = 1'b0;
        wait_tick();
        check_frame("discard", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
